// File: rtl/renkon_bias_fetch_if.sv
// Handshake and bias-memory bundle between the layer controller and renkon_bias_fetch.
// master: controller plus bias memory side; slave: the fetch sequencer.
interface renkon_bias_fetch_if #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned BWIDTH = 10,
  parameter int unsigned CORE   = 8
);
  localparam int unsigned NW = $clog2(CORE + 1);

  logic                     req;
  logic        [BWIDTH-1:0] base_addr;
  logic        [NW-1:0]     n_load;
  logic                     busy;
  logic                     done;
  logic                     mem_re;
  logic        [BWIDTH-1:0] mem_addr;
  logic signed [DWIDTH-1:0] mem_rdata;
  logic        [CORE-1:0]   breg_we;
  logic signed [DWIDTH-1:0] read_bias;

  modport master (
    output req, base_addr, n_load, mem_rdata,
    input  busy, done, mem_re, mem_addr, breg_we, read_bias
  );

  modport slave (
    input  req, base_addr, n_load, mem_rdata,
    output busy, done, mem_re, mem_addr, breg_we, read_bias
  );
endinterface

// File: rtl/renkon_bias_fetch.sv
// Bias-load sequencer: reads n_eff consecutive bias words and writes them one-hot into bias units.
// Define RENKON_BIAS_ZERO_FILL_EN to also load the remaining units with zero (FILL state).
module renkon_bias_fetch #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned BWIDTH = 10,
  parameter int unsigned CORE   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  renkon_bias_fetch_if.slave    bus
);
  localparam int unsigned NW = $clog2(CORE + 1);
  localparam int unsigned IW = (CORE > 1) ? $clog2(CORE) : 1;
  localparam logic [NW-1:0] CoreN = NW'(CORE);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
`ifdef RENKON_BIAS_ZERO_FILL_EN
    , StFill
`endif
  } state_e;

  state_e                   state_q, state_d;
  logic        [BWIDTH-1:0] addr_q, addr_d;
  logic        [NW-1:0]     n_eff_q, n_eff_d;
  logic        [IW-1:0]     i_q, i_d;
  logic                     drain_q, drain_d;
  logic                     v1_q, v1_d;
  logic        [IW-1:0]     idx1_q, idx1_d;
  logic        [CORE-1:0]   breg_we_q, breg_we_d;
  logic signed [DWIDTH-1:0] read_bias_q, read_bias_d;
`ifdef RENKON_BIAS_ZERO_FILL_EN
  logic        [IW-1:0]     u_q, u_d;
`endif
  logic        [NW-1:0]     n_clamp;

  function automatic logic [CORE-1:0] onehot(input logic [IW-1:0] idx);
    logic [CORE-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  assign n_clamp = (bus.n_load > CoreN) ? CoreN : bus.n_load;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    n_eff_d     = n_eff_q;
    i_d         = i_q;
    drain_d     = drain_q;
    v1_d        = (state_q == StRead);
    idx1_d      = i_q;
    breg_we_d   = '0;
    read_bias_d = read_bias_q;
`ifdef RENKON_BIAS_ZERO_FILL_EN
    u_d         = u_q;
`endif

    // Return pipeline: word arrives the cycle after the read, is written the cycle after that.
    if (v1_q) begin
      breg_we_d   = onehot(idx1_q);
      read_bias_d = bus.mem_rdata;
    end

    case (state_q)
      StIdle: begin
        if (bus.req) begin
          n_eff_d = n_clamp;
          addr_d  = bus.base_addr;
          i_d     = '0;
          drain_d = 1'b0;
          if (n_clamp == '0) begin
`ifdef RENKON_BIAS_ZERO_FILL_EN
            state_d     = StFill;
            u_d         = '0;
            breg_we_d   = onehot('0);
            read_bias_d = '0;
`else
            // Single busy cycle before DONE: a one-cycle drain.
            state_d = StDrain;
            drain_d = 1'b1;
`endif
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        i_d = i_q + 1'b1;
        if (NW'(i_q) == n_eff_q - 1'b1) begin
          state_d = StDrain;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      StDrain: begin
        drain_d = 1'b1;
        if (drain_q) begin
`ifdef RENKON_BIAS_ZERO_FILL_EN
          if (n_eff_q < CoreN) begin
            state_d     = StFill;
            u_d         = IW'(n_eff_q);
            breg_we_d   = onehot(IW'(n_eff_q));
            read_bias_d = '0;
          end else begin
            state_d = StDone;
          end
`else
          state_d = StDone;
`endif
        end
      end
`ifdef RENKON_BIAS_ZERO_FILL_EN
      StFill: begin
        if (u_q == IW'(CORE - 1)) begin
          state_d = StDone;
        end else begin
          u_d         = u_q + 1'b1;
          breg_we_d   = onehot(u_q + 1'b1);
          read_bias_d = '0;
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      n_eff_q     <= '0;
      i_q         <= '0;
      drain_q     <= 1'b0;
      v1_q        <= 1'b0;
      idx1_q      <= '0;
      breg_we_q   <= '0;
      read_bias_q <= '0;
`ifdef RENKON_BIAS_ZERO_FILL_EN
      u_q         <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      n_eff_q     <= n_eff_d;
      i_q         <= i_d;
      drain_q     <= drain_d;
      v1_q        <= v1_d;
      idx1_q      <= idx1_d;
      breg_we_q   <= breg_we_d;
      read_bias_q <= read_bias_d;
`ifdef RENKON_BIAS_ZERO_FILL_EN
      u_q         <= u_d;
`endif
    end
  end

  assign bus.mem_re    = (state_q == StRead);
  assign bus.mem_addr  = addr_q;
  assign bus.busy      = (state_q != StIdle) && (state_q != StDone);
  assign bus.done      = (state_q == StDone);
  assign bus.breg_we   = breg_we_q;
  assign bus.read_bias = read_bias_q;

endmodule
